halve_tokens: RTL

HALVE_TOKENS -- requirements
Module: halve_tokens

---
 rtl/halve_tokens.sv | 89 ++++++++
 1 files changed

// File: rtl/halve_tokens.sv
// halve_tokens
//   Token-halving stage: every two input tokens on `a` become one output
//   token. Completed pairs queue in a pending counter that downstream drains
//   one per cycle with `ready`. `eof` enforces pair alignment at the end of
//   a burst by discarding any orphan token.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous active-low reset
//   a          input token, one per cycle when 1
//   eof        end-of-burst marker, checks pair alignment
//   ready      downstream accepts one output token this cycle
//   b          output token valid (pending != 0)
//   half       an unpaired input token is held
//   overflow   sticky: a completed pair was dropped because pending was full
//   odd_error  sticky: eof arrived with an unpaired token held
module halve_tokens #(
    parameter int unsigned MAX_PENDING = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic eof,
    input  logic ready,
    output logic b,
    output logic half,
    output logic overflow,
    output logic odd_error
);

    localparam int unsigned PW = (MAX_PENDING < 1) ? 1 : $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] P_MAX = PW'(MAX_PENDING);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    logic [PW-1:0] r_pending;
    logic          r_half;
    logic          r_overflow;
    logic          r_odd_error;

    logic w_complete;
    logic w_consume;
    logic w_half_a;
    logic w_orphan;
    logic w_full;

    always_comb begin
        w_complete = a & r_half;
        w_consume  = ready & (r_pending != '0);
        // half after this cycle's token, before the eof check
        w_half_a   = r_half ^ a;
        w_orphan   = eof & w_half_a;
        w_full     = (r_pending == P_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending   <= '0;
            r_half      <= 1'b0;
            r_overflow  <= 1'b0;
            r_odd_error <= 1'b0;
        end else begin
            // eof always leaves half clear: either it was already 0 after
            // processing `a`, or the orphan is discarded.
            r_half <= w_half_a & ~eof;

            if (w_orphan) begin
                r_odd_error <= 1'b1;
            end

            // Completion and consumption together cancel, so a full counter
            // only drops a pair when nothing is drained that cycle.
            if (w_complete && !w_consume) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pending <= r_pending + P_ONE;
                end
            end else if (!w_complete && w_consume) begin
                r_pending <= r_pending - P_ONE;
            end
        end
    end

    assign b         = (r_pending != '0);
    assign half      = r_half;
    assign overflow  = r_overflow;
    assign odd_error = r_odd_error;

endmodule
